// File: rtl/frame_writer.sv
// frame_writer: streams pixels into frame RAM at consecutive addresses, tracking x/y; one write per accept, registered.
// Optional FRAME_CLEAR_EN adds clear_req and a CLEAR state that fills the whole frame with CLEAR_COLOUR.
module frame_writer #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240,
  parameter int AW     = 16,
`ifdef FRAME_CLEAR_EN
  parameter int DW     = 9,
  parameter logic [DW-1:0] CLEAR_COLOUR = '0
`else
  parameter int DW     = 9
`endif
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
`ifdef FRAME_CLEAR_EN
  input  logic          clear_req,
`endif
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  output logic [7:0]    x,
  output logic [7:0]    y,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]    X_LAST    = 8'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
`ifdef FRAME_CLEAR_EN
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
`else
    S_DONE  = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic          wr_vld;
  logic [DW-1:0] wr_dat;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    wr_vld     = 1'b0;
    wr_dat     = pix_data;
    pix_ready  = (state_q == S_WRITE);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
`ifdef FRAME_CLEAR_EN
        if (clear_req) begin
          state_d = S_CLEAR;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end else
`endif
        if (start) begin
          state_d = S_WRITE;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_WRITE: begin
        // pix_ready is Moore, so an accept is simply pix_valid while in WRITE
        if (pix_valid) begin
          wr_vld = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
          end else begin
            addr_d = addr_q + 1'b1;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
      end
`ifdef FRAME_CLEAR_EN
      S_CLEAR: begin
        wr_vld = 1'b1;
        wr_dat = CLEAR_COLOUR;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mem_wren <= wr_vld;
      if (wr_vld) begin
        mem_addr <= addr_q;
        mem_data <= wr_dat;
      end
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: per-cycle behavioural model plus directed literal checks.
module tb_frame_writer;
  localparam int W = 240;
  localparam int H = 240;
  localparam int N = W * H;
  localparam logic [8:0] CLR = 9'h1FF;

  logic       clk = 1'b0;
  logic       resetn, start, pix_valid, pix_ready, mem_wren, busy, frame_done;
  logic [8:0] pix_data, mem_data;
  logic [15:0] mem_addr;
  logic [7:0] x, y;
  logic       clr_in;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_done = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

`ifdef FRAME_CLEAR_EN
  logic clear_req;
  assign clr_in = clear_req;
  frame_writer #(.WIDTH(W), .HEIGHT(H), .AW(16), .DW(9), .CLEAR_COLOUR(CLR)) dut (
    .clk(clk), .resetn(resetn), .start(start), .clear_req(clear_req),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .x(x), .y(y), .busy(busy), .frame_done(frame_done));
`else
  assign clr_in = 1'b0;
  frame_writer #(.WIDTH(W), .HEIGHT(H), .AW(16), .DW(9)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .x(x), .y(y), .busy(busy), .frame_done(frame_done));
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 writing, 2 done, 3 clearing; cnt = pixels written this frame.
  int         m_phase = 0;
  int         m_cnt = 0;
  bit         m_rst = 0;
  bit         e_wren = 0;
  int         e_addr = 0;
  logic [8:0] e_data = '0;

  always @(posedge clk) begin
    m_rst = 0;
    if (!resetn) begin
      m_phase = 0; m_cnt = 0; e_wren = 0; m_rst = 1;
    end else begin
      case (m_phase)
        0: begin
          e_wren = 0;
          if (clr_in) begin m_phase = 3; m_cnt = 0; end
          else if (start) begin m_phase = 1; m_cnt = 0; end
        end
        1: begin
          e_wren = pix_valid;
          if (pix_valid) begin
            e_addr = m_cnt; e_data = pix_data; m_cnt++;
            if (m_cnt == N) begin m_phase = 2; m_cnt = 0; end
          end
        end
        2: begin e_wren = 0; m_phase = 0; end
        default: begin
          e_wren = 1; e_addr = m_cnt; e_data = CLR; m_cnt++;
          if (m_cnt == N) begin m_phase = 2; m_cnt = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pix_ready", pix_ready, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("frame_done", frame_done, m_phase == 2);
      chk("mem_wren", mem_wren, e_wren);
      if (e_wren) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data", mem_data, e_data);
      end
      if (m_rst) begin
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
      end
      if (m_phase != 3) begin
        chk("x", x, m_cnt % W);
        chk("y", y, m_cnt / W);
      end
      if (mem_wren === 1'b1) n_wr++;
      if (frame_done === 1'b1) n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int guard;
    resetn = 0; start = 0; pix_valid = 0; pix_data = '0;
`ifdef FRAME_CLEAR_EN
    clear_req = 0;
`endif
    step();
    chk_en = 1;
    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_pix_ready", pix_ready, 0);
    resetn = 1;
    step();
    n_wr = 0; n_done = 0;

`ifdef FRAME_CLEAR_EN
    // clear wins over start when both are raised in idle
    clear_req = 1; start = 1;
    step();
    clear_req = 0; start = 0;
    chk("clear_busy", busy, 1);
    chk("clear_no_ready", pix_ready, 0);
    for (int i = 0; i < N; i++) step();
    chk("clear_done_pulse", frame_done, 1);
    chk("clear_last_addr", mem_addr, N - 1);
    chk("clear_last_data", mem_data, CLR);
    step();
    chk("clear_idle", busy, 0);
    chk("clear_writes", n_wr, N);
    chk("clear_dones", n_done, 1);
`else
    // full frame at full rate, data = address low bits
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < N; i++) begin
      pix_valid = 1;
      pix_data = 9'(i);
      start = ($urandom_range(0, 49) == 0);
      step();
      if (i == W - 1) begin
        chk("row_wrap_x", x, 0);
        chk("row_wrap_y", y, 1);
        chk("row_wrap_addr", mem_addr, W - 1);
      end
      if (i == W) chk("row1_first_addr", mem_addr, W);
      if (i == N - 2) begin
        chk("last_x", x, W - 1);
        chk("last_y", y, H - 1);
      end
    end
    pix_valid = 0;
    chk("done_pulse", frame_done, 1);
    chk("done_last_wren", mem_wren, 1);
    chk("done_last_addr", mem_addr, N - 1);
    start = 1;  // ignored in DONE
    step();
    start = 0;
    chk("idle_after_done", busy, 0);
    step();
    chk("start_in_done_ignored", busy, 0);
    chk("frame_writes", n_wr, N);
    chk("frame_dones", n_done, 1);
`endif

    // row wrap, random stalls, then reset mid-frame at address 1000
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < W; i++) begin
      pix_valid = 1; pix_data = 9'($urandom);
      step();
    end
    chk("b_row_x", x, 0);
    chk("b_row_y", y, 1);
    acc = W;
    guard = 0;
    while (acc < 1000 && guard < 5000) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data = 9'($urandom);
      start = ($urandom_range(0, 19) == 0);
      step();
      if (pix_valid) acc++;
      guard++;
    end
    start = 0;
    chk("b_reached_1000", acc, 1000);
    chk("b_addr_999", mem_addr, 999);
    resetn = 0; pix_valid = 1;
    step();
    resetn = 1; pix_valid = 0;
    chk("mid_rst_wren", mem_wren, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", mem_data, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);

    // stall pattern 1,0,0,1 with a stray start in the middle
    start = 1;
    step();
    start = 0;
    pix_valid = 1; pix_data = 9'h0AA;
    step();
    chk("stall_w0_wren", mem_wren, 1);
    chk("stall_w0_addr", mem_addr, 0);
    chk("stall_w0_data", mem_data, 9'h0AA);
    pix_valid = 0; start = 1;
    step();
    start = 0;
    chk("stall_gap_wren", mem_wren, 0);
    chk("stall_gap_x", x, 1);
    step();
    chk("stall_gap2_wren", mem_wren, 0);
    pix_valid = 1; pix_data = 9'h155;
    step();
    pix_valid = 0;
    chk("stall_w1_wren", mem_wren, 1);
    chk("stall_w1_addr", mem_addr, 1);
    chk("stall_w1_data", mem_data, 9'h155);
    chk("stall_x", x, 2);
    step();

    resetn = 0;
    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_writer.md
# frame_writer

Write-side companion to the display read-out counter. It accepts a pixel stream over a valid/ready handshake and writes each pixel into the on-chip frame buffer at consecutive addresses 0 … WIDTH*HEIGHT-1. It tracks the x/y position and signals frame completion. It sits between the pixel source (image loader / processing stage) and the write port of the dual-port frame RAM, whose read port is swept by the display counter.

## Interface
- WIDTH, 240: pixels per row.
- HEIGHT, 240: rows per frame; default frame = 57600 pixels.
- AW, 16: address width; must satisfy 2^AW ≥ WIDTH*HEIGHT.
- DW, 9: pixel data width.
- CLEAR_COLOUR, 0: fill value used by the clear feature.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  begin a new frame; sampled only in IDLE.
- pix_valid  in  1  source has a pixel on pix_data.
- pix_data  in  DW  pixel value.
- pix_ready  out  1  block accepts a pixel this cycle.
- mem_addr  out  AW  RAM write address (registered).
- mem_data  out  DW  RAM write data (registered).
- mem_wren  out  1  RAM write enable (registered, one cycle per pixel).
- x  out  8  column of the next pixel to be accepted.
- y  out  8  row of the next pixel to be accepted.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last write of a frame.
- clear_req  in  1  present only with FRAME_CLEAR_EN; start a fill.

## Operation
- States: IDLE, WRITE, DONE; CLEAR is added with FRAME_CLEAR_EN.
- IDLE: pix_ready=0. On start=1, go to WRITE and zero addr/x/y.
- WRITE: pix_ready=1; pix_ready is decoded from the state register only (Moore output), never from pix_valid.
- Accept when pix_valid & pix_ready.
  - Next edge: mem_addr←addr, mem_data←pix_data, mem_wren←1.
  - addr←addr+1.
  - x←x+1; when x=WIDTH-1, x←0 and y←y+1.
- Address is a running counter. No multiplier.
- No accept: mem_wren←0 and addr/x/y hold. Stalls of any length are legal.
- When the accept is at addr=WIDTH*HEIGHT-1: go to DONE, and addr/x/y wrap to 0.
- DONE: lasts one cycle. frame_done=1, pix_ready=0. Then go to IDLE.
- start is ignored outside IDLE. start held high in IDLE across DONE→IDLE begins the next frame on the following cycle.
- Reset (any state, mid-frame included): state=IDLE, addr=x=y=0, mem_addr=0, mem_data=0, mem_wren=0, frame_done=0, busy=0, pix_ready=0. Partially written RAM contents are left as-is.

## Timing
- Latency: pixel accepted at edge k appears on mem_addr/mem_data/mem_wren after edge k, and is written by the RAM at edge k+1.
- Throughput: one pixel per cycle at full rate.
  - Full frame with pix_valid constantly high: WIDTH*HEIGHT cycles in WRITE, then 1 cycle DONE.
- Last write: mem_wren for addr 57599 is high in the same cycle as frame_done.
- busy rises the cycle after start is sampled. It falls the cycle after DONE.
- x/y/addr are never ≥ WIDTH / HEIGHT / WIDTH*HEIGHT.

## Configuration
- FRAME_CLEAR_EN defined:
  - clear_req port exists. clear_req=1 in IDLE (priority over start) enters CLEAR.
  - CLEAR writes CLEAR_COLOUR to every address 0…WIDTH*HEIGHT-1, one per cycle, pix_ready=0.
  - After the final address, go to DONE (frame_done pulse) and then IDLE.
  - Fill time is WIDTH*HEIGHT+1 cycles from entering CLEAR to IDLE.
- FRAME_CLEAR_EN undefined: no clear_req port, no CLEAR state; behaviour is exactly as described above.

## Test plan
- Reset then start, pix_valid=1 continuously, pix_data=addr[8:0] → 57600 writes, mem_addr 0…57599 in order, mem_data matches. frame_done pulses once with the 57599 write. busy falls one cycle later.
- Row wrap: after 240 accepts → x=0, y=1, next mem_addr=240. After 57599 accepts → x=239, y=239.
- Backpressure-free stall: pix_valid toggles 1,0,0,1 → exactly two writes, at addr 0 then 1. mem_wren low on idle cycles; addr holds.
- Reset asserted mid-frame at addr 1000 → next cycle all outputs 0, state IDLE. A new start restarts at mem_addr 0.
- start pulsed during WRITE and during DONE → ignored; no restart and no address change.
- With FRAME_CLEAR_EN, CLEAR_COLOUR=9'h1FF: clear_req and start both high in IDLE → clear wins; 57600 writes of 1FF, then frame_done. Without the macro, the same bench minus clear_req passes the first scenario.
